// File: rtl/uart_cmd_ctrl.sv
// ASCII command front-end: parses "wAADD" / "rAA" hex commands from a UART byte
// stream, drives a simple register bus and sends a short ASCII reply.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ       = 50000000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       cmd_busy,
  output logic       err,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, DO_WR, DO_RD, RD_WAIT,
    TX_LOAD, TX_GAP, TX_WAIT
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Handshake: rx_valid is a single-cycle strobe with no backpressure; bytes
  // that arrive while a command executes or a reply is sent are dropped.
  // tx_start is only raised when tx_busy is low, and tx_busy is ignored for
  // the one cycle after tx_start (TX_GAP) because the UART asserts it late.

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_sh_q, addr_sh_d;
  logic [3:0]      data_hi_q, data_hi_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][7:0] resp_q, resp_d;
  logic [1:0]      resp_idx_q, resp_idx_d;
  logic [1:0]      resp_last_q, resp_last_d;
  logic            err_q, err_d;

  logic       hex_ok;
  logic [3:0] nib;
  logic       in_hex;
  logic       timeout;

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      hex_decode = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) hex_decode = {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) hex_decode = {1'b1, c[3:0] + 4'd9};
    else                               hex_decode = 5'b0_0000;
  endfunction

  function automatic logic [7:0] nib_ascii(input logic [3:0] n);
    nib_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_sh_d   = addr_sh_q;
    data_hi_d   = data_hi_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    resp_d      = resp_q;
    resp_idx_d  = resp_idx_q;
    resp_last_d = resp_last_q;
    err_d       = 1'b0;
    reg_we      = 1'b0;
    reg_re      = 1'b0;
    tx_start    = 1'b0;
    {hex_ok, nib} = hex_decode(rx_data);

    in_hex  = (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
              (state_q == DATA_HI) || (state_q == DATA_LO);
    cnt_d   = (in_hex && !rx_valid) ? cnt_q + 1'b1 : '0;
    timeout = in_hex && !rx_valid && (cnt_q == TO_LAST);

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == 8'h77 || rx_data == 8'h72)) begin
          is_wr_d = (rx_data == 8'h77);
          state_d = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (rx_valid && hex_ok) begin
          addr_sh_d[7:4] = nib;
          state_d        = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (rx_valid && hex_ok) begin
          addr_sh_d[3:0] = nib;
          if (is_wr_q) begin
            state_d = DATA_HI;
          end else begin
            reg_addr_d = {addr_sh_q[7:4], nib};
            state_d    = DO_RD;
          end
        end
      end
      DATA_HI: begin
        if (rx_valid && hex_ok) begin
          data_hi_d = nib;
          state_d   = DATA_LO;
        end
      end
      DATA_LO: begin
        // Address/data commit only here so an aborted command leaves them intact.
        if (rx_valid && hex_ok) begin
          reg_addr_d  = addr_sh_q;
          reg_wdata_d = {data_hi_q, nib};
          state_d     = DO_WR;
        end
      end
      DO_WR: begin
        reg_we      = 1'b1;
        resp_d[0]   = 8'h4B;
        resp_d[1]   = 8'h0D;
        resp_d[2]   = 8'h0A;
        resp_d[3]   = 8'h00;
        resp_idx_d  = 2'd0;
        resp_last_d = 2'd2;
        state_d     = TX_LOAD;
      end
      DO_RD: begin
        reg_re  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        resp_d[0]   = nib_ascii(reg_rdata[7:4]);
        resp_d[1]   = nib_ascii(reg_rdata[3:0]);
        resp_d[2]   = 8'h0D;
        resp_d[3]   = 8'h0A;
        resp_idx_d  = 2'd0;
        resp_last_d = 2'd3;
        state_d     = TX_LOAD;
      end
      TX_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = TX_GAP;
        end
      end
      TX_GAP: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          if (resp_idx_q == resp_last_q) begin
            state_d = IDLE;
          end else begin
            resp_idx_d = resp_idx_q + 2'd1;
            state_d    = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Aborts override whatever the hex state decided above.
    if (in_hex && rx_valid && !hex_ok) begin
      err_d       = 1'b1;
      resp_d[0]   = 8'h3F;
      resp_d[1]   = 8'h0D;
      resp_d[2]   = 8'h0A;
      resp_d[3]   = 8'h00;
      resp_idx_d  = 2'd0;
      resp_last_d = 2'd2;
      addr_sh_d   = addr_sh_q;
      data_hi_d   = data_hi_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      state_d     = TX_LOAD;
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      addr_sh_q   <= 8'h00;
      data_hi_q   <= 4'h0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      cnt_q       <= '0;
      resp_q      <= '0;
      resp_idx_q  <= 2'd0;
      resp_last_q <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_hi_q   <= data_hi_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      resp_idx_q  <= resp_idx_d;
      resp_last_q <= resp_last_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = resp_q[resp_idx_q];
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign err       = err_q;
  assign cmd_busy  = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: UART TX and register-file models, scoreboard queues
// of expected TX bytes and bus accesses, one task per scenario.
module tb_uart_cmd_ctrl;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       cmd_busy;
  logic       err;
  logic [3:0] dbg_state;

  uart_cmd_ctrl #(.CLK_FREQ(10000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .cmd_busy(cmd_busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_tx_q[$], obs_tx_q[$];
  logic [15:0] exp_we_q[$], obs_we_q[$];
  logic [7:0]  exp_re_q[$], obs_re_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  ref_mem[256];
  int err_cnt = 0, last_rx_cyc = 0, we_lat = -1, re_lat = -1, err_lat = -1;
  int busy_cnt = 0;
  logic tx_pend = 1'b0;
  string hex_digits = "0123456789ABCDEF";

  // Observation side: everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) last_rx_cyc = cyc;
    if (tx_start) begin
      obs_tx_q.push_back(tx_data);
      tx_pend = 1'b1;
    end
    if (reg_we) begin
      obs_we_q.push_back({reg_addr, reg_wdata});
      mem[reg_addr] = reg_wdata;
      we_lat = cyc - last_rx_cyc;
    end
    if (reg_re) begin
      obs_re_q.push_back(reg_addr);
      reg_rdata = mem[reg_addr];
      re_lat = cyc - last_rx_cyc;
    end
    if (err) begin
      err_cnt++;
      err_lat = cyc - last_rx_cyc;
    end
  end

  // UART TX model: busy rises the cycle after tx_start and lasts 20 cycles.
  always @(posedge clk) begin
    #1;
    if (tx_pend) begin
      tx_busy = 1'b1;
      busy_cnt = 20;
      tx_pend = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return hex_digits[n];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!cmd_busy && !tx_busy && !tx_pend) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_obs();
    obs_tx_q.delete(); obs_we_q.delete(); obs_re_q.delete();
    exp_tx_q.delete(); exp_we_q.delete(); exp_re_q.delete();
    err_cnt = 0; we_lat = -1; re_lat = -1; err_lat = -1;
  endtask

  task automatic push_read_resp(input logic [7:0] a);
    exp_re_q.push_back(a);
    exp_tx_q.push_back(to_hex(ref_mem[a][7:4]));
    exp_tx_q.push_back(to_hex(ref_mem[a][3:0]));
    exp_tx_q.push_back(8'h0D);
    exp_tx_q.push_back(8'h0A);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 8;
    if (tx_start !== 1'b0)   begin bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    if (reg_we !== 1'b0)     begin bad++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
    if (reg_re !== 1'b0)     begin bad++; $display("FAIL reset_reg_re got %b want 0", reg_re); end
    if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got %b want 0", err); end
    if (cmd_busy !== 1'b0)   begin bad++; $display("FAIL reset_cmd_busy got %b want 0", cmd_busy); end
    if (tx_data !== 8'h00)   begin bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    if (reg_addr !== 8'h00)  begin bad++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
    if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_reg_wdata got %h want 00", reg_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] e, o;
    logic [15:0] ew, ow;
    clear_obs();
    ref_mem[8'h01] = 8'hAA;
    exp_we_q.push_back({8'h01, 8'hAA});
    exp_tx_q.push_back(8'h4B); exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
    send_str("w01AA");
    wait_idle(ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL write_idle got busy want idle"); end
    if (we_lat !== 1) begin bad++; $display("FAIL write_we_latency got %0d want 1", we_lat); end
    if (obs_tx_q.size() !== exp_tx_q.size()) begin
      bad++; $display("FAIL write_tx_count got %0d want %0d", obs_tx_q.size(), exp_tx_q.size());
    end
    while (exp_we_q.size() > 0) begin
      ew = exp_we_q.pop_front();
      ow = (obs_we_q.size() > 0) ? obs_we_q.pop_front() : 16'hxxxx;
      total++;
      if (ow !== ew) begin bad++; $display("FAIL write_bus got %h want %h", ow, ew); end
    end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      o = (obs_tx_q.size() > 0) ? obs_tx_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) begin bad++; $display("FAIL write_tx_byte got %h want %h", o, e); end
    end
    total++;
    if (obs_we_q.size() !== 0) begin bad++; $display("FAIL write_extra_we got %0d want 0", obs_we_q.size()); end
  endtask

  task automatic test_read(input string name, input string cmd, input logic [7:0] a);
    bit ok;
    logic [7:0] e, o;
    clear_obs();
    push_read_resp(a);
    send_str(cmd);
    wait_idle(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL %s_idle got busy want idle", name); end
    if (re_lat !== 1) begin bad++; $display("FAIL %s_re_latency got %0d want 1", name, re_lat); end
    if (obs_re_q.size() !== 1) begin bad++; $display("FAIL %s_re_count got %0d want 1", name, obs_re_q.size()); end
    if (obs_tx_q.size() !== exp_tx_q.size()) begin
      bad++; $display("FAIL %s_tx_count got %0d want %0d", name, obs_tx_q.size(), exp_tx_q.size());
    end
    while (exp_re_q.size() > 0) begin
      e = exp_re_q.pop_front();
      o = (obs_re_q.size() > 0) ? obs_re_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) begin bad++; $display("FAIL %s_re_addr got %h want %h", name, o, e); end
    end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      o = (obs_tx_q.size() > 0) ? obs_tx_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) begin bad++; $display("FAIL %s_tx_byte got %h want %h", name, o, e); end
    end
  endtask

  task automatic test_bad_hex();
    bit ok;
    logic [7:0] e, o;
    clear_obs();
    exp_tx_q.push_back(8'h3F); exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
    send_str("r1g");
    wait_idle(ok);
    repeat (3) @(negedge clk);
    total += 7;
    if (!ok) begin bad++; $display("FAIL badhex_idle got busy want idle"); end
    if (err_cnt !== 1) begin bad++; $display("FAIL badhex_err_count got %0d want 1", err_cnt); end
    if (err_lat !== 1) begin bad++; $display("FAIL badhex_err_latency got %0d want 1", err_lat); end
    if (obs_re_q.size() !== 0) begin bad++; $display("FAIL badhex_re_count got %0d want 0", obs_re_q.size()); end
    if (cmd_busy !== 1'b0) begin bad++; $display("FAIL badhex_cmd_busy got %b want 0", cmd_busy); end
    if (reg_addr !== 8'h01) begin bad++; $display("FAIL badhex_addr_hold got %h want 01", reg_addr); end
    if (obs_tx_q.size() !== exp_tx_q.size()) begin
      bad++; $display("FAIL badhex_tx_count got %0d want %0d", obs_tx_q.size(), exp_tx_q.size());
    end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      o = (obs_tx_q.size() > 0) ? obs_tx_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) begin bad++; $display("FAIL badhex_tx_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    clear_obs();
    send_str("w0");
    seen = 1'b0;
    for (int i = 0; i < TO + 200; i++) begin
      @(negedge clk);
      if (err_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (50) @(negedge clk);
    total += 6;
    if (!seen) begin bad++; $display("FAIL timeout_err got none want pulse"); end
    if (err_lat < TO || err_lat > TO + 2) begin
      bad++; $display("FAIL timeout_latency got %0d want %0d..%0d", err_lat, TO, TO + 2);
    end
    if (err_cnt !== 1) begin bad++; $display("FAIL timeout_err_count got %0d want 1", err_cnt); end
    if (obs_tx_q.size() !== 0) begin bad++; $display("FAIL timeout_tx_count got %0d want 0", obs_tx_q.size()); end
    if (obs_we_q.size() !== 0) begin bad++; $display("FAIL timeout_we_count got %0d want 0", obs_we_q.size()); end
    if (cmd_busy !== 1'b0) begin bad++; $display("FAIL timeout_cmd_busy got %b want 0", cmd_busy); end
    test_read("after_timeout", "r0f", 8'h0F);
  endtask

  task automatic test_busy_drop();
    bit ok, started;
    logic [7:0] e, o;
    logic [15:0] ew, ow;
    clear_obs();
    send_byte(8'h78);
    ref_mem[8'h3C] = 8'hB7;
    exp_we_q.push_back({8'h3C, 8'hB7});
    exp_tx_q.push_back(8'h4B); exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'h0A);
    send_str("w3Cb7");
    started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obs_tx_q.size() > 0) begin
        started = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h72);
      repeat ($urandom_range(0, 9)) @(posedge clk);
    end
    wait_idle(ok);
    repeat (20) @(negedge clk);
    total += 5;
    if (!started) begin bad++; $display("FAIL drop_tx_start got none want tx"); end
    if (!ok) begin bad++; $display("FAIL drop_idle got busy want idle"); end
    if (cmd_busy !== 1'b0) begin bad++; $display("FAIL drop_cmd_busy got %b want 0", cmd_busy); end
    if (obs_re_q.size() !== 0) begin bad++; $display("FAIL drop_re_count got %0d want 0", obs_re_q.size()); end
    if (obs_tx_q.size() !== exp_tx_q.size()) begin
      bad++; $display("FAIL drop_tx_count got %0d want %0d", obs_tx_q.size(), exp_tx_q.size());
    end
    while (exp_we_q.size() > 0) begin
      ew = exp_we_q.pop_front();
      ow = (obs_we_q.size() > 0) ? obs_we_q.pop_front() : 16'hxxxx;
      total++;
      if (ow !== ew) begin bad++; $display("FAIL drop_bus got %h want %h", ow, ew); end
    end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      o = (obs_tx_q.size() > 0) ? obs_tx_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) begin bad++; $display("FAIL drop_tx_byte got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    test_read("back_to_back", "r3C", 8'h3C);
  endtask

  task automatic test_reset_mid();
    bit reached;
    clear_obs();
    send_str("r01");
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (obs_tx_q.size() >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total += 9;
    if (!reached) begin bad++; $display("FAIL rstmid_second_byte got %0d want 2", obs_tx_q.size()); end
    if (tx_start !== 1'b0)   begin bad++; $display("FAIL rstmid_tx_start got %b want 0", tx_start); end
    if (reg_we !== 1'b0)     begin bad++; $display("FAIL rstmid_reg_we got %b want 0", reg_we); end
    if (reg_re !== 1'b0)     begin bad++; $display("FAIL rstmid_reg_re got %b want 0", reg_re); end
    if (err !== 1'b0)        begin bad++; $display("FAIL rstmid_err got %b want 0", err); end
    if (cmd_busy !== 1'b0)   begin bad++; $display("FAIL rstmid_cmd_busy got %b want 0", cmd_busy); end
    if (tx_data !== 8'h00)   begin bad++; $display("FAIL rstmid_tx_data got %h want 00", tx_data); end
    if (reg_addr !== 8'h00)  begin bad++; $display("FAIL rstmid_reg_addr got %h want 00", reg_addr); end
    if (reg_wdata !== 8'h00) begin bad++; $display("FAIL rstmid_reg_wdata got %h want 00", reg_wdata); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_tx_q.delete();
    repeat (100) @(negedge clk);
    total += 2;
    if (obs_tx_q.size() !== 0) begin bad++; $display("FAIL rstmid_no_tx got %0d want 0", obs_tx_q.size()); end
    if (cmd_busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got %b want 0", cmd_busy); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_write();
    test_read("read", "r01", 8'h01);
    test_bad_hex();
    test_timeout();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
